// File: rtl/orv64_cache_noc_sched.sv
// rtl/orv64_cache_noc_sched.sv - credit-limited round-robin scheduler from ORV64 cache requesters onto the CPU NOC port
// Optional per-requester stall counters are enabled by defining ORV64_CACHE_NOC_SCHED_PERF_EN.

package orv64_cache_noc_pkg;
    localparam int CPUNOC_TID_SRCID_SIZE = 4;
    localparam int CPUNOC_TID_TID_SIZE   = 4;

    typedef struct packed {
        logic [CPUNOC_TID_SRCID_SIZE-1:0] src;
        logic [CPUNOC_TID_TID_SIZE-1:0]   tid;
    } cpunoc_tid_t;

    typedef struct packed {
        cpunoc_tid_t req_tid;
        logic [1:0]  req_type;
        logic [39:0] req_paddr;
        logic [63:0] req_data;
    } cpu_cache_if_req_t;

    typedef struct packed {
        cpunoc_tid_t resp_tid;
        logic [63:0] resp_data;
    } cpu_cache_if_resp_t;
endpackage

module orv64_cache_noc_sched
    import orv64_cache_noc_pkg::*;
#(
    parameter int N_REQ           = 5,
    parameter int MAX_OUTSTANDING = 4,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_REQ-1:0]                cpu_if_req_valid,
    input  cpu_cache_if_req_t [N_REQ-1:0]   cpu_if_req,
    output logic [N_REQ-1:0]                cpu_if_req_ready,
    output logic [N_REQ-1:0]                cpu_if_resp_valid,
    output cpu_cache_if_resp_t [N_REQ-1:0]  cpu_if_resp,
    input  logic [N_REQ-1:0]                cpu_if_resp_ready,
    output logic                            cache_if_req_valid,
    output cpu_cache_if_req_t               cache_if_req,
    input  logic                            cache_if_req_ready,
    input  logic                            cache_if_resp_valid,
    input  cpu_cache_if_resp_t              cache_if_resp,
    output logic                            cache_if_resp_ready,
    output logic [CNT_W*N_REQ-1:0]          outstanding,
    output logic                            resp_src_err
`ifdef ORV64_CACHE_NOC_SCHED_PERF_EN
    ,
    output logic [16*N_REQ-1:0]             perf_stall_cnt
`endif
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int SRC_W = CPUNOC_TID_SRCID_SIZE;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  cnt_q [N_REQ];
    logic [CNT_W-1:0]  cnt_d [N_REQ];
    logic              slot_valid_q, slot_valid_d;
    cpu_cache_if_req_t slot_q, slot_d;
    logic              src_err_q, src_err_d;

    logic [N_REQ-1:0]  eligible;
    logic [N_REQ-1:0]  grant_vec;
    logic [N_REQ-1:0]  resp_sel;
    logic [N_REQ-1:0]  resp_hs;
    logic              slot_free;
    logic              grant_found;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  cand_idx;
    logic [SRC_W-1:0]  resp_src;
    logic              resp_match;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = cpu_if_req_valid[i] && (cnt_q[i] < CNT_MAX);
        end
    end

    assign slot_free = !slot_valid_q || cache_if_req_ready;

    // Search starts one past the last winner so the previous winner has lowest priority.
    always_comb begin
        int cand;
        cand        = 0;
        cand_idx    = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!grant_found && eligible[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        grant_vec = '0;
        if (!rst && slot_free && grant_found) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    assign cpu_if_req_ready = grant_vec;

    // A response only counts as matched when its source actually has a request in flight.
    always_comb begin
        resp_src   = cache_if_resp.resp_tid.src;
        resp_match = 1'b0;
        resp_sel   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (resp_src == SRC_W'(i) && cnt_q[i] != '0) begin
                resp_match  = 1'b1;
                resp_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        cpu_if_resp_valid   = '0;
        cache_if_resp_ready = 1'b0;
        if (!rst) begin
            cpu_if_resp_valid   = cache_if_resp_valid ? resp_sel : '0;
            cache_if_resp_ready = resp_match ? |(resp_sel & cpu_if_resp_ready) : 1'b1;
        end
    end

    assign resp_hs = cpu_if_resp_valid & cpu_if_resp_ready;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            cpu_if_resp[i] = cache_if_resp;
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (grant_vec[i] && !resp_hs[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (!grant_vec[i] && resp_hs[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_d       = slot_q;
        rr_ptr_d     = rr_ptr_q;
        if (|grant_vec) begin
            slot_valid_d            = 1'b1;
            slot_d                  = cpu_if_req[grant_idx];
            slot_d.req_tid.src      = SRC_W'(grant_idx);
            rr_ptr_d                = grant_idx;
        end else if (cache_if_req_ready) begin
            slot_valid_d = 1'b0;
        end
    end

    assign src_err_d = src_err_q || (cache_if_resp_valid && !resp_match);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q     <= IDX_W'(N_REQ - 1);
            slot_valid_q <= 1'b0;
            slot_q       <= '0;
            src_err_q    <= 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            slot_valid_q <= slot_valid_d;
            slot_q       <= slot_d;
            src_err_q    <= src_err_d;
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign cache_if_req_valid = slot_valid_q;
    assign cache_if_req       = slot_q;
    assign resp_src_err       = src_err_q;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            outstanding[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

`ifdef ORV64_CACHE_NOC_SCHED_PERF_EN
    logic [15:0] stall_q [N_REQ];
    logic [15:0] stall_d [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            stall_d[i] = stall_q[i];
            if (cpu_if_req_valid[i] && !cpu_if_req_ready[i] && stall_q[i] != 16'hFFFF) begin
                stall_d[i] = stall_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                stall_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                stall_q[i] <= stall_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            perf_stall_cnt[i*16 +: 16] = stall_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_orv64_cache_noc_sched.sv
// tb/tb_orv64_cache_noc_sched.sv - self-checking bench for orv64_cache_noc_sched
module tb_orv64_cache_noc_sched;
    import orv64_cache_noc_pkg::*;

    localparam int N    = 5;
    localparam int MAXO = 4;
    localparam int CW   = 3;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]             cpu_if_req_valid;
    cpu_cache_if_req_t [N-1:0]  cpu_if_req;
    logic [N-1:0]             cpu_if_req_ready;
    logic [N-1:0]             cpu_if_resp_valid;
    cpu_cache_if_resp_t [N-1:0] cpu_if_resp;
    logic [N-1:0]             cpu_if_resp_ready;
    logic                     cache_if_req_valid;
    cpu_cache_if_req_t        cache_if_req;
    logic                     cache_if_req_ready;
    logic                     cache_if_resp_valid;
    cpu_cache_if_resp_t       cache_if_resp;
    logic                     cache_if_resp_ready;
    logic [CW*N-1:0]          outstanding;
    logic                     resp_src_err;
`ifdef ORV64_CACHE_NOC_SCHED_PERF_EN
    logic [16*N-1:0]          perf_stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    int                m_cnt [N];
    int                m_rr;
    bit                m_slot_v;
    cpu_cache_if_req_t m_slot;
    bit                m_err;

    int          e_grant;
    int          e_src;
    bit          e_match;
    logic [N-1:0] e_req_ready;
    logic [N-1:0] e_resp_valid;
    logic        e_resp_ready;

    orv64_cache_noc_sched #(.N_REQ(N), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk),
        .rst(rst),
        .cpu_if_req_valid(cpu_if_req_valid),
        .cpu_if_req(cpu_if_req),
        .cpu_if_req_ready(cpu_if_req_ready),
        .cpu_if_resp_valid(cpu_if_resp_valid),
        .cpu_if_resp(cpu_if_resp),
        .cpu_if_resp_ready(cpu_if_resp_ready),
        .cache_if_req_valid(cache_if_req_valid),
        .cache_if_req(cache_if_req),
        .cache_if_req_ready(cache_if_req_ready),
        .cache_if_resp_valid(cache_if_resp_valid),
        .cache_if_resp(cache_if_resp),
        .cache_if_resp_ready(cache_if_resp_ready),
        .outstanding(outstanding),
        .resp_src_err(resp_src_err)
`ifdef ORV64_CACHE_NOC_SCHED_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [CW*N-1:0] pack_cnt();
        logic [CW*N-1:0] p;
        for (int i = 0; i < N; i++) p[i*CW +: CW] = CW'(m_cnt[i]);
        return p;
    endfunction

    task automatic model_init();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_rr     = N - 1;
        m_slot_v = 0;
        m_slot   = '0;
        m_err    = 0;
    endtask

    // Expected combinational behaviour for the inputs currently applied.
    task automatic model_eval();
        int j;
        e_grant = -1;
        if (!m_slot_v || cache_if_req_ready) begin
            for (int k = 1; k <= N; k++) begin
                j = (m_rr + k) % N;
                if (e_grant < 0 && cpu_if_req_valid[j] && m_cnt[j] < MAXO) e_grant = j;
            end
        end
        e_req_ready = '0;
        if (e_grant >= 0) e_req_ready[e_grant] = 1'b1;
        e_src   = int'(cache_if_resp.resp_tid.src);
        e_match = 0;
        if (e_src < N) begin
            if (m_cnt[e_src] > 0) e_match = 1;
        end
        e_resp_valid = '0;
        if (e_match && cache_if_resp_valid) e_resp_valid[e_src] = 1'b1;
        e_resp_ready = e_match ? cpu_if_resp_ready[e_src] : 1'b1;
    endtask

    task automatic model_commit();
        if (e_grant >= 0) m_cnt[e_grant]++;
        if (e_match && cache_if_resp_valid && cpu_if_resp_ready[e_src]) m_cnt[e_src]--;
        if (cache_if_resp_valid && !e_match) m_err = 1;
        if (e_grant >= 0) begin
            m_slot             = cpu_if_req[e_grant];
            m_slot.req_tid.src = 4'(e_grant);
            m_slot_v           = 1;
            m_rr               = e_grant;
        end else if (cache_if_req_ready) begin
            m_slot_v = 0;
        end
    endtask

    task automatic tick();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_reqs();
        for (int i = 0; i < N; i++) begin
            cpu_if_req[i].req_tid.src = 4'($urandom);
            cpu_if_req[i].req_tid.tid = 4'($urandom);
            cpu_if_req[i].req_type    = 2'($urandom);
            cpu_if_req[i].req_paddr   = {8'($urandom), 32'($urandom)};
            cpu_if_req[i].req_data    = {32'($urandom), 32'($urandom)};
        end
    endtask

    task automatic idle();
        cpu_if_req_valid    = '0;
        cpu_if_resp_ready   = '0;
        cache_if_req_ready  = 1'b1;
        cache_if_resp_valid = 1'b0;
        cache_if_resp       = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_init();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rand_reqs();
        cpu_if_req_valid    = '1;
        cache_if_req_ready  = 1'b1;
        cpu_if_resp_ready   = '1;
        cache_if_resp_valid = 1'b1;
        cache_if_resp       = '0;
        @(posedge clk);
        #1;
        checks++; if (cpu_if_req_ready !== '0) begin errors++; $display("FAIL rst_req_ready: got %b expected 0", cpu_if_req_ready); end
        checks++; if (cpu_if_resp_valid !== '0) begin errors++; $display("FAIL rst_resp_valid: got %b expected 0", cpu_if_resp_valid); end
        checks++; if (cache_if_resp_ready !== 1'b0) begin errors++; $display("FAIL rst_resp_ready: got %b expected 0", cache_if_resp_ready); end
        checks++; if (cache_if_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b expected 0", cache_if_req_valid); end
        checks++; if (cache_if_req !== '0) begin errors++; $display("FAIL rst_req_data: got %h expected 0", cache_if_req); end
        checks++; if (outstanding !== '0) begin errors++; $display("FAIL rst_outstanding: got %h expected 0", outstanding); end
        checks++; if (resp_src_err !== 1'b0) begin errors++; $display("FAIL rst_src_err: got %b expected 0", resp_src_err); end
        idle();
        rst = 1'b0;
        model_init();
    endtask

    task automatic test_fill();
        logic [N-1:0] exp;
        int nreq;
        nreq = 0;
        cpu_if_req_valid   = '1;
        cache_if_req_ready = 1'b1;
        rand_reqs();
        for (int c = 0; c < 25; c++) begin
            #1;
            model_eval();
            exp = '0;
            if (c < 20) exp[c % 5] = 1'b1;
            checks++; if (cpu_if_req_ready !== exp) begin errors++; $display("FAIL fill_grant c=%0d: got %b expected %b", c, cpu_if_req_ready, exp); end
            checks++; if (cache_if_req_valid !== (c >= 1 && c <= 20)) begin errors++; $display("FAIL fill_req_valid c=%0d: got %b", c, cache_if_req_valid); end
            if (cache_if_req_valid) begin
                nreq++;
                checks++; if (cache_if_req.req_tid.src !== 4'((c - 1) % 5)) begin errors++; $display("FAIL fill_src c=%0d: got %0d expected %0d", c, cache_if_req.req_tid.src, (c - 1) % 5); end
            end
            tick();
            rand_reqs();
        end
        checks++; if (nreq != 20) begin errors++; $display("FAIL fill_noc_count: got %0d expected 20", nreq); end
        checks++; if (outstanding !== {5{3'd4}}) begin errors++; $display("FAIL fill_outstanding: got %h expected %h", outstanding, {5{3'd4}}); end
    endtask

    task automatic test_resp_route();
        cpu_if_req_valid             = 5'b00100;
        cache_if_resp_valid          = 1'b1;
        cache_if_resp.resp_tid.src   = 4'd2;
        cache_if_resp.resp_data      = {32'($urandom), 32'($urandom)};
        cpu_if_resp_ready            = 5'b00100;
        #1;
        model_eval();
        checks++; if (cpu_if_resp_valid !== 5'b00100) begin errors++; $display("FAIL route_valid: got %b expected 00100", cpu_if_resp_valid); end
        checks++; if (cache_if_resp_ready !== 1'b1) begin errors++; $display("FAIL route_ready: got %b expected 1", cache_if_resp_ready); end
        checks++; if (cpu_if_req_ready !== '0) begin errors++; $display("FAIL route_full_grant: got %b expected 0", cpu_if_req_ready); end
        checks++; if (cpu_if_resp[4] !== cache_if_resp) begin errors++; $display("FAIL route_bcast: got %h expected %h", cpu_if_resp[4], cache_if_resp); end
        tick();
        cache_if_resp_valid = 1'b0;
        #1;
        model_eval();
        checks++; if (outstanding[2*CW +: CW] !== 3'd3) begin errors++; $display("FAIL route_cnt_dec: got %0d expected 3", outstanding[2*CW +: CW]); end
        checks++; if (cpu_if_req_ready !== 5'b00100) begin errors++; $display("FAIL route_regrant: got %b expected 00100", cpu_if_req_ready); end
        tick();
        checks++; if (outstanding[2*CW +: CW] !== 3'd4) begin errors++; $display("FAIL route_cnt_inc: got %0d expected 4", outstanding[2*CW +: CW]); end
        idle();
    endtask

    task automatic test_backpressure();
        do_reset();
        cpu_if_req_valid   = 5'b00011;
        cache_if_req_ready = 1'b0;
        rand_reqs();
        #1;
        model_eval();
        checks++; if (cpu_if_req_ready !== 5'b00001) begin errors++; $display("FAIL bp_first: got %b expected 00001", cpu_if_req_ready); end
        tick();
        for (int c = 0; c < 3; c++) begin
            rand_reqs();
            #1;
            model_eval();
            checks++; if (cpu_if_req_ready !== '0) begin errors++; $display("FAIL bp_hold_grant c=%0d: got %b expected 0", c, cpu_if_req_ready); end
            checks++; if (cache_if_req_valid !== 1'b1 || cache_if_req !== m_slot) begin errors++; $display("FAIL bp_hold_slot c=%0d: got %h expected %h", c, cache_if_req, m_slot); end
            tick();
        end
        cache_if_req_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            model_eval();
            checks++; if (cpu_if_req_ready !== ((c % 2 == 0) ? 5'b00010 : 5'b00001)) begin errors++; $display("FAIL bp_release_grant c=%0d: got %b", c, cpu_if_req_ready); end
            checks++; if (cache_if_req_valid !== 1'b1 || cache_if_req.req_tid.src !== ((c % 2 == 0) ? 4'd0 : 4'd1)) begin errors++; $display("FAIL bp_release_src c=%0d: got %0d", c, cache_if_req.req_tid.src); end
            checks++; if (cache_if_req !== m_slot) begin errors++; $display("FAIL bp_release_slot c=%0d: got %h expected %h", c, cache_if_req, m_slot); end
            tick();
            rand_reqs();
        end
        idle();
    endtask

    task automatic test_same_cycle();
        do_reset();
        cpu_if_req_valid = 5'b00010;
        rand_reqs();
        for (int c = 0; c < 2; c++) begin
            #1;
            model_eval();
            checks++; if (cpu_if_req_ready !== 5'b00010) begin errors++; $display("FAIL same_pre c=%0d: got %b expected 00010", c, cpu_if_req_ready); end
            tick();
        end
        cache_if_resp_valid        = 1'b1;
        cache_if_resp.resp_tid.src = 4'd1;
        cpu_if_resp_ready          = 5'b00010;
        #1;
        model_eval();
        checks++; if (cpu_if_req_ready !== 5'b00010 || cpu_if_resp_valid !== 5'b00010) begin errors++; $display("FAIL same_both: got grant %b resp %b expected 00010 00010", cpu_if_req_ready, cpu_if_resp_valid); end
        tick();
        idle();
        #1;
        checks++; if (outstanding[1*CW +: CW] !== 3'd2) begin errors++; $display("FAIL same_cnt: got %0d expected 2", outstanding[1*CW +: CW]); end
    endtask

    task automatic test_random();
        int cands [$];
        int pick;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rand_reqs();
            cpu_if_req_valid   = N'($urandom);
            cache_if_req_ready = ($urandom_range(0, 9) < 7);
            cpu_if_resp_ready  = N'($urandom);
            cands.delete();
            for (int i = 0; i < N; i++) if (m_cnt[i] > 0) cands.push_back(i);
            cache_if_resp.resp_data = {32'($urandom), 32'($urandom)};
            cache_if_resp.resp_tid  = cpunoc_tid_t'($urandom);
            cache_if_resp_valid     = 1'b0;
            if (cands.size() > 0 && $urandom_range(0, 9) < 6) begin
                pick = cands[$urandom_range(0, cands.size() - 1)];
                cache_if_resp.resp_tid.src = 4'(pick);
                cache_if_resp_valid        = 1'b1;
            end
            #1;
            model_eval();
            checks++; if (cpu_if_req_ready !== e_req_ready) begin errors++; $display("FAIL rnd_grant c=%0d: got %b expected %b", c, cpu_if_req_ready, e_req_ready); end
            checks++; if (cpu_if_resp_valid !== e_resp_valid) begin errors++; $display("FAIL rnd_resp_valid c=%0d: got %b expected %b", c, cpu_if_resp_valid, e_resp_valid); end
            checks++; if (cache_if_resp_ready !== e_resp_ready) begin errors++; $display("FAIL rnd_resp_ready c=%0d: got %b expected %b", c, cache_if_resp_ready, e_resp_ready); end
            checks++; if (cache_if_req_valid !== m_slot_v) begin errors++; $display("FAIL rnd_req_valid c=%0d: got %b expected %b", c, cache_if_req_valid, m_slot_v); end
            if (m_slot_v) begin
                checks++; if (cache_if_req !== m_slot) begin errors++; $display("FAIL rnd_req_data c=%0d: got %h expected %h", c, cache_if_req, m_slot); end
            end
            checks++; if (outstanding !== pack_cnt()) begin errors++; $display("FAIL rnd_outstanding c=%0d: got %h expected %h", c, outstanding, pack_cnt()); end
            checks++; if (resp_src_err !== m_err) begin errors++; $display("FAIL rnd_src_err c=%0d: got %b expected %b", c, resp_src_err, m_err); end
            tick();
        end
        idle();
    endtask

    task automatic test_unmatched();
        do_reset();
        cache_if_resp_valid        = 1'b1;
        cache_if_resp.resp_tid.src = 4'd3;
        cpu_if_resp_ready          = '1;
        #1;
        model_eval();
        checks++; if (cache_if_resp_ready !== 1'b1 || cpu_if_resp_valid !== '0) begin errors++; $display("FAIL unm_src3: got ready %b valid %b expected 1 0", cache_if_resp_ready, cpu_if_resp_valid); end
        tick();
        checks++; if (resp_src_err !== 1'b1) begin errors++; $display("FAIL unm_err_set: got %b expected 1", resp_src_err); end
        cache_if_resp.resp_tid.src = 4'd7;
        #1;
        model_eval();
        checks++; if (cache_if_resp_ready !== 1'b1 || cpu_if_resp_valid !== '0) begin errors++; $display("FAIL unm_src7: got ready %b valid %b expected 1 0", cache_if_resp_ready, cpu_if_resp_valid); end
        tick();
        idle();
        for (int c = 0; c < 5; c++) tick();
        checks++; if (resp_src_err !== 1'b1) begin errors++; $display("FAIL unm_err_sticky: got %b expected 1", resp_src_err); end
        do_reset();
        checks++; if (resp_src_err !== 1'b0) begin errors++; $display("FAIL unm_err_clear: got %b expected 0", resp_src_err); end
    endtask

    task automatic test_midreset();
        do_reset();
        cpu_if_req_valid = '1;
        rand_reqs();
        for (int c = 0; c < 8; c++) begin
            #1;
            model_eval();
            tick();
        end
        rst = 1'b1;
        #1;
        checks++; if (outstanding !== '0 || cache_if_req_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_state: got cnt %h valid %b expected 0 0", outstanding, cache_if_req_valid); end
        checks++; if (cpu_if_req_ready !== '0) begin errors++; $display("FAIL mid_rst_grant: got %b expected 0", cpu_if_req_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_init();
        idle();
        cache_if_resp_valid        = 1'b1;
        cache_if_resp.resp_tid.src = 4'd0;
        cpu_if_resp_ready          = '1;
        #1;
        model_eval();
        checks++; if (cpu_if_resp_valid !== '0 || cache_if_resp_ready !== 1'b1) begin errors++; $display("FAIL mid_stale_resp: got valid %b ready %b expected 0 1", cpu_if_resp_valid, cache_if_resp_ready); end
        tick();
        idle();
        checks++; if (resp_src_err !== 1'b1) begin errors++; $display("FAIL mid_stale_err: got %b expected 1", resp_src_err); end
    endtask

`ifdef ORV64_CACHE_NOC_SCHED_PERF_EN
    task automatic test_perf();
        do_reset();
        cpu_if_req_valid = 5'b10000;
        rand_reqs();
        for (int c = 0; c < 14; c++) begin
            #1;
            model_eval();
            tick();
        end
        checks++; if (perf_stall_cnt[4*16 +: 16] !== 16'd10) begin errors++; $display("FAIL perf_stall4: got %0d expected 10", perf_stall_cnt[4*16 +: 16]); end
        checks++; if (perf_stall_cnt[0 +: 16] !== 16'd0) begin errors++; $display("FAIL perf_stall0: got %0d expected 0", perf_stall_cnt[0 +: 16]); end
        idle();
    endtask
`endif

    initial begin
        idle();
        test_reset();
        test_fill();
        test_resp_route();
        test_backpressure();
        test_same_cycle();
        test_random();
        test_unmatched();
        test_midreset();
`ifdef ORV64_CACHE_NOC_SCHED_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
